// File: rtl/spart_echo_ctrl.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes every received byte.
// Build option SPART_ECHO_FIFO_EN replaces the single holding register with a FIFO_DEPTH-entry FIFO.
module spart_echo_ctrl #(
    parameter logic [15:0] DIV_0      = 16'h028A,
    parameter logic [15:0] DIV_1      = 16'h0145,
    parameter logic [15:0] DIV_2      = 16'h00A2,
    parameter logic [15:0] DIV_3      = 16'h0051,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic        cfg_done,
    output logic [7:0]  rx_byte,
    output logic [15:0] echo_cnt
);

    typedef enum logic [2:0] {
        CFG_LO = 3'd0,
        CFG_HI = 3'd1,
        IDLE   = 3'd2,
        RX_RD  = 3'd3,
        TX_WR  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        run_r;
    logic [1:0]  shadow_r;
    logic [15:0] div_s;
    logic [7:0]  dout_s;
    logic        push_s;
    logic        pop_s;
    logic        buf_empty_s;
    logic        buf_full_s;
    logic [7:0]  buf_head_s;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   div_sel = DIV_0;
            2'b01:   div_sel = DIV_1;
            2'b10:   div_sel = DIV_2;
            2'b11:   div_sel = DIV_3;
            default: div_sel = DIV_0;
        endcase
    endfunction

    assign div_s   = div_sel(shadow_r);
    assign push_s  = run_r && (state_r == RX_RD);
    assign pop_s   = run_r && (state_r == TX_WR);
    assign databus = (iocs && !iorw) ? dout_s : 8'hzz;

`ifdef SPART_ECHO_FIFO_EN
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE_C = (PTR_W + 1)'(1);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    assign buf_empty_s = (count_r == {(PTR_W + 1){1'b0}});
    assign buf_full_s  = (count_r == DEPTH_C);
    assign buf_head_s  = mem_r[rd_ptr_r];

    // FIFO storage; contents need no reset because count_r qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= databus;
        end
    end

    // FIFO pointers and occupancy; push and pop never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            count_r  <= count_r + CNT_ONE_C;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            count_r  <= count_r - CNT_ONE_C;
        end
    end
`else
    // FIFO_DEPTH has no meaning with a single holding register.
    localparam int unused_depth_c = FIFO_DEPTH;

    logic [7:0] hold_r;
    logic       valid_r;

    assign buf_empty_s = !valid_r;
    assign buf_full_s  = valid_r;
    assign buf_head_s  = hold_r;

    // Single-byte holding register with valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (push_s) begin
            hold_r  <= databus;
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end
    end
`endif

    // State register; run_r keeps the bus quiet for the first post-reset cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CFG_LO;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            run_r   <= 1'b1;
        end
    end

    // Next-state: reconfig only on an empty buffer, then TX before RX.
    always_comb begin
        state_next_s = state_r;
        if (!run_r) begin
            state_next_s = CFG_LO;
        end else begin
            case (state_r)
                CFG_LO:  state_next_s = CFG_HI;
                CFG_HI:  state_next_s = IDLE;
                RX_RD:   state_next_s = IDLE;
                TX_WR:   state_next_s = IDLE;
                IDLE: begin
                    if ((br_cfg != shadow_r) && buf_empty_s) begin
                        state_next_s = CFG_LO;
                    end else if (!buf_empty_s && tbr) begin
                        state_next_s = TX_WR;
                    end else if (rda && !buf_full_s) begin
                        state_next_s = RX_RD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                default: state_next_s = CFG_LO;
            endcase
        end
    end

    // Bus outputs decoded from registered state only.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        dout_s = 8'h00;
        if (run_r) begin
            case (state_r)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    dout_s = div_s[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    dout_s = div_s[15:8];
                end
                RX_RD: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = 2'b00;
                end
                TX_WR: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b00;
                    dout_s = buf_head_s;
                end
                default: begin
                    iocs   = 1'b0;
                    iorw   = 1'b1;
                    ioaddr = 2'b00;
                    dout_s = 8'h00;
                end
            endcase
        end else begin
            iocs   = 1'b0;
            iorw   = 1'b1;
            ioaddr = 2'b00;
            dout_s = 8'h00;
        end
    end

    // Baud shadow is captured on every entry into divisor programming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 2'b00;
        end else if (state_next_s == CFG_LO) begin
            shadow_r <= br_cfg;
        end
    end

    // Status outputs: cfg_done low while the divisor is being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_done <= 1'b0;
            rx_byte  <= 8'h00;
            echo_cnt <= 16'h0000;
        end else begin
            cfg_done <= (state_next_s == IDLE) || (state_next_s == RX_RD) ||
                        (state_next_s == TX_WR);
            if (push_s) begin
                rx_byte <= databus;
            end
            if (pop_s) begin
                echo_cnt <= echo_cnt + 16'd1;
            end
        end
    end

endmodule
